apb_image_regfile: RTL and testbench
====================================

# apb_image_regfile

APB slave register file that sits directly downstream of the APB bus driver and upstream of the CatRecognizer compute core. It decodes zero-wait-state APB write/read transfers into a control register at address 0 and a packed-pixel image store at addresses 1..2^Amba_Addr_Depth. It generates a one-cycle start pulse to the core, holds the image stable while the core is busy, and captures the core's done/result into readable status bits.

## Interface
- Amba_Word, 24: APB data width; one word holds three 8-bit pixels, MSB byte = first pixel.
- Amba_Addr_Depth, 12: image store holds 2^Amba_Addr_Depth words; PADDR is Amba_Addr_Depth+1 bits.
- Data_Depth, 8: pixel width; Amba_Word must equal 3*Data_Depth.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  Amba_Addr_Depth+1  word address.
- PWDATA  in  Amba_Word  write data.
- PRDATA  out  Amba_Word  read data, valid in access phase.
- start  out  1  one-cycle start pulse to core.
- busy  out  1  core computing; image store write-locked.
- core_rd_addr  in  Amba_Addr_Depth  core image read address (0 = image word 1).
- core_rd_data  out  Amba_Word  image word, registered, 1-cycle latency.
- core_done  in  1  one-cycle pulse from core, computation finished.
- core_result  in  1  classification result, valid with core_done.

## Operation
- APB FSM: IDLE -> SETUP when PSEL & !PENABLE. SETUP -> ACCESS when PSEL & PENABLE. ACCESS -> SETUP if PSEL & !PENABLE, ACCESS -> IDLE if !PSEL, otherwise stays in ACCESS. The access phase is recognised only on the SETUP->ACCESS edge, so a PENABLE held for several cycles commits exactly one write.
- Write commit occurs on the SETUP->ACCESS edge when PWRITE=1.
  - Addr 0 (CTRL): bit0 = start_work.
    - If bit0=1 and not busy: start pulse, busy set, done cleared.
    - If bit0=1 and busy: ignored, err set.
    - If bit0=0: clears done and err.
  - Addr 1..2^Amba_Addr_Depth: write to image word PADDR-1 if not busy. If busy, the write is dropped and err is set.
  - Addr above 2^Amba_Addr_Depth: the write is dropped silently.
- Read: PRDATA is registered on the IDLE/ACCESS->SETUP edge from PADDR, so it is stable through the access phase.
  - CTRL readback: {zeros, err[3], result[2], done[1], busy[0]}.
  - Image address: the stored word.
  - Out-of-range address: 0.
- Core FSM: IDLE -> START (start=1 for exactly one cycle) -> BUSY. BUSY -> IDLE on core_done, with done=1 and result=core_result latched. core_done outside BUSY is ignored.
- Image store: 1 write port (APB), 2 registered read ports (APB, core). It has no reset; contents persist across rst.

## Timing
- Reset values: PRDATA=0, start=0, busy=0, core_rd_data=0. Internal done, result and err are 0; both FSMs are in IDLE.
- Start: CTRL write commits at edge N; start=1 and busy=1 from edge N+1; start drops at N+2.
- Done: core_done sampled at edge M; busy=0 and done=1 visible after edge M. A new start write is accepted from edge M+1.
- core_rd_data: the word at core_rd_addr sampled at edge K is presented after edge K, in every state.
- Same-edge CTRL start write and core_done: done processing wins. The FSM returns to IDLE, and the start write is treated as a busy-write, so err is set.
- rst asserted mid-BUSY: returns to IDLE next edge, busy=0, no done, start not re-issued. The image is retained.
- Back-to-back transfers (ACCESS->SETUP with no IDLE): each commits once.

## Test plan
- Reset: drive rst for 3 cycles with random bus activity -> all outputs 0 and CTRL read = 0x000000.
- Image write/read: write 0x0A0B0C to addr 1 and 0xFFFFFF to addr 4096, then read both back -> same values. Core reads addr 0 and 4095 -> same values one cycle later. Read addr 5000 -> 0.
- Start: write CTRL=0x000001 -> single-cycle start pulse, busy=1, CTRL read = 0x000001. Hold PENABLE 3 cycles on that write -> still exactly one pulse.
- Busy lock: while busy, write 0x123456 to addr 1 -> addr 1 still 0x0A0B0C, CTRL bit3=1. A second CTRL=1 write -> no start pulse.
- Done: pulse core_done with core_result=1 -> busy=0, CTRL read = 0x000006 (err also set if the previous test ran). Write CTRL=0 -> CTRL read = 0x000000.
- Reset mid-BUSY: start, then rst for 1 cycle -> busy=0, done=0, no start pulse. Image addr 1 still reads 0x0A0B0C.

Source files
------------

// File: rtl/apb_image_regfile.sv
// APB register file: a control/status word at address 0 and a packed-pixel image store
// at addresses 1..2^Amba_Addr_Depth, with a start/busy/done handshake to the compute core.
module apb_image_regfile #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12,
  parameter int Data_Depth      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [Amba_Addr_Depth:0]   PADDR,
  input  logic [Amba_Word-1:0]       PWDATA,
  output logic [Amba_Word-1:0]       PRDATA,
  output logic                       start,
  output logic                       busy,
  input  logic [Amba_Addr_Depth-1:0] core_rd_addr,
  output logic [Amba_Word-1:0]       core_rd_data,
  input  logic                       core_done,
  input  logic                       core_result
);

  localparam int unsigned Depth = 1 << Amba_Addr_Depth;
  localparam logic [Amba_Addr_Depth:0] LastAddr = (Amba_Addr_Depth + 1)'(Depth);

  if (Amba_Word != 3 * Data_Depth) begin : g_width_check
    $error("apb_image_regfile: Amba_Word must hold exactly three pixels");
  end

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;
  typedef enum logic [1:0] {CORE_IDLE, CORE_START, CORE_BUSY} core_state_e;

  apb_state_e                 apb_q;
  core_state_e                core_q;
  logic                       start_q;
  logic                       busy_q;
  logic                       go_q;
  logic                       done_q;
  logic                       result_q;
  logic                       err_q;
  logic [Amba_Word-1:0]       prdata_q;
  logic [Amba_Word-1:0]       core_rd_q;
  logic [Amba_Word-1:0]       mem_q [Depth];

  logic                       setup_edge_s;
  logic                       wr_s;
  logic                       addr_is_ctrl_s;
  logic                       addr_is_img_s;
  logic [Amba_Addr_Depth-1:0] img_idx_s;
  logic                       locked_s;
  logic                       ctrl_wr_s;
  logic                       start_req_s;
  logic                       img_we_s;
  logic                       err_set_s;
  logic                       clr_s;
  logic [Amba_Word-1:0]       status_s;

  // Transfer decode; go_q covers the cycle between an accepted start write and START.
  always_comb begin
    setup_edge_s   = PSEL && !PENABLE && ((apb_q == APB_IDLE) || (apb_q == APB_ACCESS));
    wr_s           = PSEL && PENABLE && PWRITE && (apb_q == APB_SETUP);
    addr_is_ctrl_s = (PADDR == '0);
    addr_is_img_s  = !addr_is_ctrl_s && (PADDR <= LastAddr);
    img_idx_s      = PADDR[Amba_Addr_Depth-1:0] - Amba_Addr_Depth'(1);
    locked_s       = busy_q || go_q;
    ctrl_wr_s      = wr_s && addr_is_ctrl_s;
    start_req_s    = ctrl_wr_s && PWDATA[0] && !locked_s;
    img_we_s       = wr_s && addr_is_img_s && !locked_s && !rst;
    clr_s          = ctrl_wr_s && !PWDATA[0];
    status_s       = Amba_Word'({err_q, result_q, done_q, busy_q});
    if (addr_is_ctrl_s) begin
      err_set_s = wr_s && PWDATA[0] && locked_s;
    end else begin
      err_set_s = wr_s && addr_is_img_s && locked_s;
    end
  end

  // APB protocol tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      apb_q <= APB_IDLE;
    end else begin
      case (apb_q)
        APB_IDLE:   apb_q <= (PSEL && !PENABLE) ? APB_SETUP : APB_IDLE;
        APB_SETUP: begin
          if (PSEL && PENABLE) begin
            apb_q <= APB_ACCESS;
          end else if (PSEL) begin
            apb_q <= APB_SETUP;
          end else begin
            apb_q <= APB_IDLE;
          end
        end
        APB_ACCESS: begin
          if (!PSEL) begin
            apb_q <= APB_IDLE;
          end else if (!PENABLE) begin
            apb_q <= APB_SETUP;
          end else begin
            apb_q <= APB_ACCESS;
          end
        end
        default:    apb_q <= APB_IDLE;
      endcase
    end
  end

  // Core handshake FSM and status bits; done from the core overrides a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_q   <= CORE_IDLE;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      go_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      go_q <= start_req_s;
      if (err_set_s) begin
        err_q <= 1'b1;
      end else if (clr_s) begin
        err_q <= 1'b0;
      end
      if (start_req_s || clr_s) begin
        done_q   <= 1'b0;
        result_q <= 1'b0;
      end
      case (core_q)
        CORE_IDLE: begin
          start_q <= go_q;
          busy_q  <= go_q;
          core_q  <= go_q ? CORE_START : CORE_IDLE;
        end
        CORE_START: begin
          start_q <= 1'b0;
          busy_q  <= 1'b1;
          core_q  <= CORE_BUSY;
        end
        CORE_BUSY: begin
          start_q <= 1'b0;
          if (core_done) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= core_result;
            core_q   <= CORE_IDLE;
          end
        end
        default: begin
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          core_q  <= CORE_IDLE;
        end
      endcase
    end
  end

  // Image store write port; contents deliberately survive rst.
  always_ff @(posedge clk) begin
    if (img_we_s) begin
      mem_q[img_idx_s] <= PWDATA;
    end
  end

  // APB read data, captured as a transfer enters SETUP and held through ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      prdata_q <= '0;
    end else if (setup_edge_s) begin
      if (addr_is_ctrl_s) begin
        prdata_q <= status_s;
      end else if (addr_is_img_s) begin
        prdata_q <= mem_q[img_idx_s];
      end else begin
        prdata_q <= '0;
      end
    end
  end

  // Core read port, one cycle of latency in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rd_q <= '0;
    end else begin
      core_rd_q <= mem_q[core_rd_addr];
    end
  end

  assign PRDATA       = prdata_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign core_rd_data = core_rd_q;

endmodule

// File: tb/tb_apb_image_regfile.sv
// Bench for apb_image_regfile: table-driven image accesses plus hand-written
// start/busy/done sequences; read results are checked through an expectation queue.
module tb_apb_image_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [12:0] PADDR;
  logic [23:0] PWDATA, PRDATA;
  logic        start, busy;
  logic [11:0] core_rd_addr;
  logic [23:0] core_rd_data;
  logic        core_done, core_result;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cnt = 0;
  int last_start_cyc = -1;
  int commit_cyc = 0;
  int pre;
  logic [23:0] exp_q [$];

  typedef struct {
    bit          wr;
    logic [12:0] addr;
    logic [23:0] data;
  } vec_t;
  vec_t vt [16];

  apb_image_regfile dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .start(start), .busy(busy),
    .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (start === 1'b1) begin start_cnt++; last_start_cyc = cyc; end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [12:0] a, input logic [23:0] d, input int hold,
                           input logic dc, input logic dr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    step();
    PENABLE = 1'b1; core_done = dc; core_result = dr;
    step();
    commit_cyc = cyc; core_done = 1'b0; core_result = 1'b0;
    repeat (hold) step();
    PSEL = 1'b0; PENABLE = 1'b0;
    step();
  endtask

  task automatic apb_read(input string name, input logic [12:0] a, input logic [23:0] e);
    logic [23:0] x;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    exp_q.push_back(e);
    step();
    PENABLE = 1'b1;
    step();
    x = exp_q.pop_front();
    check(name, PRDATA, x);
    PSEL = 1'b0; PENABLE = 1'b0;
    step();
  endtask

  task automatic core_read(input logic [11:0] a, input logic [23:0] e);
    logic [23:0] x;
    core_rd_addr = a;
    exp_q.push_back(e);
    step();
    x = exp_q.pop_front();
    check("core_rd", core_rd_data, x);
  endtask

  initial begin
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    core_rd_addr = '0; core_done = 1'b0; core_result = 1'b0; rst = 1'b1;

    // Reset with random bus and core activity
    repeat (3) begin
      PSEL = 1'($urandom); PENABLE = 1'($urandom); PWRITE = 1'($urandom);
      PADDR = 13'($urandom); PWDATA = 24'($urandom); core_rd_addr = 12'($urandom);
      core_done = 1'($urandom); core_result = 1'($urandom);
      step();
    end
    check("rst_prdata", PRDATA, 24'h0);
    check("rst_start", 24'(start), 24'h0);
    check("rst_busy", 24'(busy), 24'h0);
    check("rst_core_rd", core_rd_data, 24'h0);
    PSEL = 1'b0; PENABLE = 1'b0; core_done = 1'b0; core_result = 1'b0;
    rst = 1'b0;
    step();
    start_cnt = 0;
    apb_read("rst_ctrl", 13'd0, 24'h000000);

    // Image store table: writes (incl. out-of-range drops) then read-backs
    vt[0]  = '{1'b1, 13'd1,    24'h0A0B0C};
    vt[1]  = '{1'b1, 13'd4096, 24'hFFFFFF};
    vt[2]  = '{1'b1, 13'd904,  24'h555555};
    vt[3]  = '{1'b1, 13'd4095, 24'h333333};
    vt[4]  = '{1'b1, 13'd5000, 24'h111111};
    vt[5]  = '{1'b1, 13'd8191, 24'h222222};
    vt[6]  = '{1'b1, 13'd4097, 24'h444444};
    vt[7]  = '{1'b0, 13'd1,    24'h0A0B0C};
    vt[8]  = '{1'b0, 13'd4096, 24'hFFFFFF};
    vt[9]  = '{1'b0, 13'd904,  24'h555555};
    vt[10] = '{1'b0, 13'd4095, 24'h333333};
    vt[11] = '{1'b0, 13'd5000, 24'h000000};
    vt[12] = '{1'b0, 13'd8191, 24'h000000};
    vt[13] = '{1'b0, 13'd4097, 24'h000000};
    vt[14] = '{1'b0, 13'd0,    24'h000000};
    vt[15] = '{1'b0, 13'd1,    24'h0A0B0C};
    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) apb_write(vt[i].addr, vt[i].data, 0, 1'b0, 1'b0);
      else          apb_read("img_rd", vt[i].addr, vt[i].data);
    end
    core_read(12'd0,    24'h0A0B0C);
    core_read(12'd4095, 24'hFFFFFF);
    core_read(12'd903,  24'h555555);
    core_read(12'd4094, 24'h333333);

    // Start with PENABLE held three cycles: exactly one pulse, one cycle after commit
    pre = start_cnt;
    apb_write(13'd0, 24'h000001, 2, 1'b0, 1'b0);
    check("start_count", 24'(start_cnt - pre), 24'd1);
    check("start_timing", 24'(last_start_cyc - commit_cyc), 24'd1);
    check("start_busy", 24'(busy), 24'h1);
    apb_read("ctrl_busy", 13'd0, 24'h000001);

    // Busy lock: image write dropped, second start ignored, err raised
    apb_write(13'd1, 24'h123456, 0, 1'b0, 1'b0);
    apb_read("locked_img", 13'd1, 24'h0A0B0C);
    apb_read("ctrl_err", 13'd0, 24'h000009);
    pre = start_cnt;
    apb_write(13'd0, 24'h000001, 0, 1'b0, 1'b0);
    repeat (3) step();
    check("no_restart", 24'(start_cnt - pre), 24'd0);

    // Done with result=1
    core_done = 1'b1; core_result = 1'b1;
    step();
    core_done = 1'b0; core_result = 1'b0;
    check("done_busy", 24'(busy), 24'h0);
    apb_read("ctrl_done", 13'd0, 24'h00000E);
    apb_write(13'd0, 24'h000000, 0, 1'b0, 1'b0);
    apb_read("ctrl_clear", 13'd0, 24'h000000);

    // Start write on the same edge as core_done: done wins, write counts as busy
    pre = start_cnt;
    apb_write(13'd0, 24'h000001, 0, 1'b0, 1'b0);
    repeat (2) step();
    check("restart_count", 24'(start_cnt - pre), 24'd1);
    pre = start_cnt;
    apb_write(13'd0, 24'h000001, 0, 1'b1, 1'b0);
    repeat (3) step();
    check("sameedge_start", 24'(start_cnt - pre), 24'd0);
    check("sameedge_busy", 24'(busy), 24'h0);
    apb_read("sameedge_ctrl", 13'd0, 24'h00000A);
    apb_write(13'd0, 24'h000000, 0, 1'b0, 1'b0);

    // Reset in the middle of BUSY
    apb_write(13'd0, 24'h000001, 0, 1'b0, 1'b0);
    repeat (2) step();
    check("pre_rst_busy", 24'(busy), 24'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", 24'(busy), 24'h0);
    pre = start_cnt;
    repeat (4) step();
    check("rst_no_start", 24'(start_cnt - pre), 24'd0);
    apb_read("rst_mid_ctrl", 13'd0, 24'h000000);
    apb_read("rst_keep_img", 13'd1, 24'h0A0B0C);

    // Back-to-back writes: ACCESS goes straight to SETUP
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 13'd10; PWDATA = 24'hABCDEF;
    step();
    PENABLE = 1'b1;
    step();
    PENABLE = 1'b0; PADDR = 13'd11; PWDATA = 24'h010203;
    step();
    PENABLE = 1'b1;
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
    step();
    apb_read("b2b_first", 13'd10, 24'hABCDEF);
    apb_read("b2b_second", 13'd11, 24'h010203);
    check("sb_empty", 24'(exp_q.size()), 24'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
